// File: rtl/regbank_write_buffer.sv
// rtl/regbank_write_buffer.sv - in-order write-back FIFO committing into a 16 x 32-bit register bank
module regbank_write_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    parameter bit          ZERO_R0   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [3:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     commit_en,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              pending,
    output logic [31:0]              q0,
    output logic [31:0]              q1,
    output logic [31:0]              q2,
    output logic [31:0]              q3,
    output logic [31:0]              q4,
    output logic [31:0]              q5,
    output logic [31:0]              q6,
    output logic [31:0]              q7,
    output logic [31:0]              q8,
    output logic [31:0]              q9,
    output logic [31:0]              q10,
    output logic [31:0]              q11,
    output logic [31:0]              q12,
    output logic [31:0]              q13,
    output logic [31:0]              q14,
    output logic [31:0]              q15
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    fifo_addr_q [DEPTH];
    logic [3:0]    fifo_addr_d [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [31:0]   regs_q [16];
    logic [31:0]   regs_d [16];
    logic          accept;
    logic          commit;

    always_comb begin
        wb_ready    = (count_q != CW'(DEPTH));
        accept      = wb_valid && wb_ready && !flush;
        commit      = commit_en && (count_q != '0) && !flush;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        regs_d      = regs_q;

        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (accept) begin
                fifo_addr_d[tail_q] = wb_addr;
                fifo_data_d[tail_q] = wb_data;
                tail_d              = tail_q + PW'(1);
            end
            if (commit) begin
                // r0 entries still pop when hardwired to zero; only the data is dropped
                if (!(ZERO_R0 && fifo_addr_q[head_q] == 4'd0)) begin
                    regs_d[fifo_addr_q[head_q]] = fifo_data_q[head_q];
                end
                head_d = head_q + PW'(1);
            end
            case ({accept, commit})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                pending[fifo_addr_q[head_q + PW'(i)]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= (ZERO_R0 && i == 0) ? 32'h0 : RESET_VAL;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            regs_q      <= regs_d;
        end
    end

    assign count = count_q;
    assign q0    = regs_q[0];
    assign q1    = regs_q[1];
    assign q2    = regs_q[2];
    assign q3    = regs_q[3];
    assign q4    = regs_q[4];
    assign q5    = regs_q[5];
    assign q6    = regs_q[6];
    assign q7    = regs_q[7];
    assign q8    = regs_q[8];
    assign q9    = regs_q[9];
    assign q10   = regs_q[10];
    assign q11   = regs_q[11];
    assign q12   = regs_q[12];
    assign q13   = regs_q[13];
    assign q14   = regs_q[14];
    assign q15   = regs_q[15];

endmodule

// File: tb/tb_regbank_write_buffer.sv
// tb/tb_regbank_write_buffer.sv - scoreboard bench for regbank_write_buffer, ZERO_R0 off and on
module tb_regbank_write_buffer;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        commit_en = 1'b0;
    logic        flush = 1'b0;

    logic        wb_ready_a, wb_ready_b;
    logic [1:0]  count_a, count_b;
    logic [15:0] pending_a, pending_b;
    wire  [31:0] qa [16];
    wire  [31:0] qb [16];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  sb_addr [$];
    logic [31:0] sb_data [$];

    always #5 clk = ~clk;

    regbank_write_buffer #(.DEPTH(2), .RESET_VAL(RV), .ZERO_R0(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready_a),
        .wb_addr(wb_addr), .wb_data(wb_data), .commit_en(commit_en), .flush(flush),
        .count(count_a), .pending(pending_a),
        .q0(qa[0]), .q1(qa[1]), .q2(qa[2]), .q3(qa[3]), .q4(qa[4]), .q5(qa[5]),
        .q6(qa[6]), .q7(qa[7]), .q8(qa[8]), .q9(qa[9]), .q10(qa[10]), .q11(qa[11]),
        .q12(qa[12]), .q13(qa[13]), .q14(qa[14]), .q15(qa[15])
    );

    regbank_write_buffer #(.DEPTH(2), .RESET_VAL(RV), .ZERO_R0(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready_b),
        .wb_addr(wb_addr), .wb_data(wb_data), .commit_en(commit_en), .flush(flush),
        .count(count_b), .pending(pending_b),
        .q0(qb[0]), .q1(qb[1]), .q2(qb[2]), .q3(qb[3]), .q4(qb[4]), .q5(qb[5]),
        .q6(qb[6]), .q7(qb[7]), .q8(qb[8]), .q9(qb[9]), .q10(qb[10]), .q11(qb[11]),
        .q12(qb[12]), .q13(qb[13]), .q14(qb[14]), .q15(qb[15])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the request until a handshake edge, recording the expected commit when it happens.
    task automatic send(input logic [3:0] a, input logic [31:0] d);
        bit done = 0;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (wb_ready_a === 1'b1 && !flush) begin
                sb_addr.push_back(a);
                sb_data.push_back(d);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        wb_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no handshake expected accept of r%0d", a);
        end
    endtask

    initial begin : monitor
        logic do_commit, do_flush;
        logic [3:0]  ea;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            do_commit = (rst_n === 1'b1) && (commit_en === 1'b1) && (flush === 1'b0) && (count_a !== 2'd0);
            do_flush  = (rst_n === 1'b1) && (flush === 1'b1);
            @(posedge clk);
            #2;
            if (do_flush) begin
                sb_addr.delete();
                sb_data.delete();
            end else if (do_commit) begin
                if (sb_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got commit expected empty queue");
                end else begin
                    ea = sb_addr.pop_front();
                    ed = sb_data.pop_front();
                    check($sformatf("commit_a_r%0d", ea), qa[ea], ed);
                    check($sformatf("commit_b_r%0d", ea), qb[ea], (ea == 4'd0) ? 32'h0 : ed);
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        cyc(2);
        check("rst_count", 32'(count_a), 0);
        check("rst_ready", 32'(wb_ready_a), 1);
        check("rst_pending", 32'(pending_a), 0);
        for (int i = 0; i < 16; i++) check($sformatf("rst_q%0d", i), qa[i], RV);
        check("rst_b_q0", qb[0], 32'h0);
        check("rst_b_q1", qb[1], RV);
        rst_n = 1'b1;
        cyc(1);

        commit_en = 1'b1;
        send(4'd5, 32'h1234_5678);
        check("acc_pending5", 32'(pending_a[5]), 1);
        check("acc_q5_not_yet", qa[5], RV);
        cyc(1);
        check("cmt_q5", qa[5], 32'h1234_5678);
        check("cmt_pending5", 32'(pending_a[5]), 0);

        commit_en = 1'b0;
        send(4'd1, 32'hA1A1_0001);
        send(4'd2, 32'hA2A2_0002);
        check("full_count", 32'(count_a), 2);
        check("full_ready", 32'(wb_ready_a), 0);
        fork
            send(4'd3, 32'hA3A3_0003);
            begin
                cyc(3);
                check("held_count", 32'(count_a), 2);
                check("held_pending", 32'(pending_a), 32'h0006);
                check("held_q1", qa[1], RV);
                commit_en = 1'b1;
            end
        join
        cyc(2);
        check("drain_count", 32'(count_a), 0);
        check("drain_q3", qa[3], 32'hA3A3_0003);

        commit_en = 1'b0;
        send(4'd3, 32'h0000_000A);
        send(4'd3, 32'h0000_000B);
        check("same_count", 32'(count_a), 2);
        check("same_pending3", 32'(pending_a[3]), 1);
        commit_en = 1'b1;
        cyc(1);
        check("same_first_q3", qa[3], 32'h0000_000A);
        check("same_first_pend3", 32'(pending_a[3]), 1);
        cyc(1);
        check("same_second_q3", qa[3], 32'h0000_000B);
        check("same_second_pend3", 32'(pending_a[3]), 0);

        send(4'd0, 32'hFFFF_FFFF);
        check("r0_count_b_queued", 32'(count_b), 1);
        cyc(1);
        check("r0_count_b", 32'(count_b), 0);
        check("r0_q0_b", qb[0], 32'h0);
        check("r0_q0_a", qa[0], 32'hFFFF_FFFF);

        commit_en = 1'b0;
        send(4'd7, 32'hC1C1_0007);
        send(4'd8, 32'hC2C2_0008);
        flush = 1'b1; wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'h9999_9999; commit_en = 1'b1;
        cyc(1);
        flush = 1'b0; wb_valid = 1'b0;
        check("flush_count", 32'(count_a), 0);
        check("flush_pending", 32'(pending_a), 0);
        check("flush_ready", 32'(wb_ready_a), 1);
        cyc(2);
        check("flush_q7", qa[7], RV);
        check("flush_q8", qa[8], RV);
        check("flush_q9", qa[9], RV);
        check("flush_q5_kept", qa[5], 32'h1234_5678);

        commit_en = 1'b0;
        send(4'd10, 32'hD0D0_000A);
        flush = 1'b1; wb_valid = 1'b1; wb_addr = 4'd11; wb_data = 32'hBBBB_000B; commit_en = 1'b1;
        cyc(1);
        flush = 1'b0; wb_valid = 1'b0;
        check("flush1_count", 32'(count_a), 0);
        check("flush1_pending", 32'(pending_a), 0);
        cyc(2);
        check("flush1_q10", qa[10], RV);
        check("flush1_q11", qa[11], RV);

        commit_en = 1'b0;
        send(4'd12, 32'hE1E1_000C);
        send(4'd13, 32'hE2E2_000D);
        check("mid_count_pre", 32'(count_a), 2);
        rst_n = 1'b0;
        #1;
        sb_addr.delete();
        sb_data.delete();
        check("mid_rst_count", 32'(count_a), 0);
        check("mid_rst_pending", 32'(pending_a), 0);
        check("mid_rst_ready", 32'(wb_ready_a), 1);
        check("mid_rst_q5", qa[5], RV);
        commit_en = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        check("mid_rst_q12", qa[12], RV);
        check("mid_rst_q13", qa[13], RV);
        check("mid_rst_count_post", 32'(count_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regbank_write_buffer.md
Name: regbank_write_buffer

Overview:
- Write side of the 32-bit register bank; sits directly upstream of the 16:1 read multiplexer.
- Accepts write-back requests through a valid/ready handshake and queues them in a small in-order FIFO.
- Commits at most one request per cycle into 16 x 32-bit registers.
- Drives all 16 register values (q0..q15) to the read mux. Exports a per-register pending scoreboard so the issue logic can detect read-after-write hazards.

Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..8.
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.
- ZERO_R0, 0, when 1 writes to register 0 are discarded and q0 is held at 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wb_valid  input  1  write request present.
- wb_ready  output  1  buffer can accept a request this cycle.
- wb_addr  input  4  destination register index.
- wb_data  input  32  write data.
- commit_en  input  1  permits the head entry to be written this cycle; 0 stalls commits.
- flush  input  1  synchronous discard of all queued, uncommitted entries.
- count  output  log2(DEPTH)+1  current FIFO occupancy.
- pending  output  16  bit i = 1 when any queued entry targets register i.
- q0..q15  output  32 each  current register contents, to the read mux.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - q0..q15 = RESET_VAL, except q0 = 0 when ZERO_R0=1.
  - FIFO empty; count=0, pending=0, wb_ready=1.
  - Any queued entries are lost, including on reset mid-operation.
- Accept: a transfer occurs on a rising edge where wb_valid && wb_ready. {wb_addr, wb_data} is written to the tail and the tail pointer advances, wrapping modulo DEPTH.
- wb_ready = (count != DEPTH). It is combinational from count only and does not depend on commit_en or wb_valid. When full, no pass-through occurs even if a commit happens in the same cycle.
- Commit: on a rising edge where commit_en && count != 0, the head entry is written to register head.addr and the head pointer advances.
  - When ZERO_R0=1 and head.addr == 0, the entry is popped and the data discarded.
- Latency: a request accepted at edge N is visible on its q output no earlier than edge N+1, provided commit_en is high in the cycle after N. An empty FIFO never writes through in the same cycle.
- Ordering: strictly in order. Two queued writes to the same register commit oldest first, so the final value is the newest.
- count update per edge: +1 on accept only, -1 on commit only, unchanged on both or neither.
- flush=1 at an edge:
  - count becomes 0 and head = tail; pending becomes 0.
  - No commit or accept takes effect that cycle; the flush has priority over both.
  - Register contents are unchanged.
- pending is combinational: the OR over valid entries of one-hot(addr).
  - It clears on the edge that commits the last queued entry for that register.
  - A register with an older entry committing and a newer entry still queued stays pending.
- Registers not targeted by a commit hold their value. q outputs are direct register outputs with no combinational path from the wb_* inputs.

Test Plan:
- Reset with RESET_VAL=32'hDEAD_BEEF -> all q = DEAD_BEEF, count=0, wb_ready=1, pending=0. Assert rst_n mid-stream with 2 entries queued -> count=0 immediately, no later commit.
- commit_en=1; write addr 5 data 32'h1234_5678 -> pending[5]=1 after the accept edge; q5=1234_5678 one edge later, with pending[5]=0 at that point.
- commit_en=0; issue 3 writes with DEPTH=2 -> the first two are accepted, wb_ready=0, count=2, and the third is held. Raise commit_en -> the third is accepted only after count drops. q values update in issue order.
- Writes r3=A then r3=B queued, then commits -> after the first commit q3=A and pending[3] stays 1; after the second q3=B and pending[3]=0.
- ZERO_R0=1; write r0=32'hFFFF_FFFF -> entry pops, count decrements, q0 stays 0. Same stimulus with ZERO_R0=0 -> q0=FFFF_FFFF.
- 2 entries queued; assert flush together with wb_valid and commit_en -> count=0, pending=0, registers unchanged, and the incoming request is not accepted.
